// File: rtl/tt_load_drain_ctrl_ovi.sv
// rtl/tt_load_drain_ctrl_ovi.sv - drains the circular load queue for one scoreboard entry per request
module tt_load_drain_ctrl_ovi #(
  parameter int LQ_DEPTH = 8,
  parameter int LQID_W   = 3,
  parameter int CNT_W    = 4,
  parameter int SBID_W   = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_drain_req,
  input  logic [SBID_W-1:0]   i_drain_sb_id,
  input  logic [CNT_W-1:0]    i_drain_ref_count,
  input  logic [LQID_W-1:0]   i_drain_lqid_start,
  output logic                o_draining,
  input  logic [LQ_DEPTH-1:0] i_lq_entry_valid,
  output logic                o_wb_valid,
  output logic [LQID_W-1:0]   o_wb_lqid,
  output logic [SBID_W-1:0]   o_wb_sb_id,
  input  logic                i_wb_ready,
  output logic                o_lq_commit,
  output logic [LQID_W-1:0]   o_dest_lqid,
  output logic                o_drain_done,
  output logic [SBID_W-1:0]   o_drain_done_sb_id,
  input  logic                i_flush
);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(LQ_DEPTH);

  state_e              state_q, state_d;
  logic [LQID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [SBID_W-1:0]   sb_id_q, sb_id_d;
  logic                fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      sb_id_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      sb_id_q     <= sb_id_d;
    end
  end

  assign o_draining = (state_q != IDLE);

  always_comb begin
    state_d            = state_q;
    ptr_d              = ptr_q;
    remaining_d        = remaining_q;
    sb_id_d            = sb_id_q;
    fire               = 1'b0;
    o_wb_valid         = 1'b0;
    o_wb_lqid          = '0;
    o_wb_sb_id         = '0;
    o_lq_commit        = 1'b0;
    o_dest_lqid        = '0;
    o_drain_done       = 1'b0;
    o_drain_done_sb_id = '0;

    case (state_q)
      IDLE: begin
        // A flush in IDLE also blocks acceptance for that cycle.
        if (i_drain_req && !i_flush) begin
          sb_id_d     = i_drain_sb_id;
          ptr_d       = i_drain_lqid_start;
          remaining_d = (i_drain_ref_count > MAX_CNT) ? MAX_CNT : i_drain_ref_count;
          state_d     = (i_drain_ref_count == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        o_wb_valid = i_lq_entry_valid[ptr_q];
        o_wb_lqid  = ptr_q;
        o_wb_sb_id = sb_id_q;
        fire       = o_wb_valid && i_wb_ready && !i_flush;
        if (i_flush) begin
          state_d = IDLE;
        end else if (fire) begin
          o_lq_commit = 1'b1;
          o_dest_lqid = ptr_q;
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!i_flush) begin
          o_drain_done       = 1'b1;
          o_drain_done_sb_id = sb_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tt_load_drain_ctrl_ovi.sv
// tb/tb_tt_load_drain_ctrl_ovi.sv - scoreboard bench for tt_load_drain_ctrl_ovi
module tb_tt_load_drain_ctrl_ovi;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       drain_req = 1'b0;
  logic [4:0] drain_sb_id = '0;
  logic [3:0] drain_cnt = '0;
  logic [2:0] drain_start = '0;
  logic       draining;
  logic [7:0] lq_valid = '0;
  logic       wb_valid;
  logic [2:0] wb_lqid;
  logic [4:0] wb_sb_id;
  logic       wb_ready = 1'b0;
  logic       lq_commit;
  logic [2:0] dest_lqid;
  logic       drain_done;
  logic [4:0] done_sb_id;
  logic       flush = 1'b0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] lqid;
    logic [4:0] sb;
    int         cyc;
  } commit_t;

  typedef struct {
    logic [4:0] sb;
    int         cyc;
  } done_t;

  commit_t cq[$];
  done_t   dq[$];

  tt_load_drain_ctrl_ovi dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_drain_req        (drain_req),
    .i_drain_sb_id      (drain_sb_id),
    .i_drain_ref_count  (drain_cnt),
    .i_drain_lqid_start (drain_start),
    .o_draining         (draining),
    .i_lq_entry_valid   (lq_valid),
    .o_wb_valid         (wb_valid),
    .o_wb_lqid          (wb_lqid),
    .o_wb_sb_id         (wb_sb_id),
    .i_wb_ready         (wb_ready),
    .o_lq_commit        (lq_commit),
    .o_dest_lqid        (dest_lqid),
    .o_drain_done       (drain_done),
    .o_drain_done_sb_id (done_sb_id),
    .i_flush            (flush)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_commit(input logic [2:0] lqid, input logic [4:0] sb, input int c);
    commit_t e;
    e.lqid = lqid; e.sb = sb; e.cyc = c;
    cq.push_back(e);
  endtask

  task automatic push_done(input logic [4:0] sb, input int c);
    done_t e;
    e.sb = sb; e.cyc = c;
    dq.push_back(e);
  endtask

  task automatic request(input logic [2:0] start, input logic [3:0] cnt, input logic [4:0] sb);
    drain_req = 1'b1; drain_start = start; drain_cnt = cnt; drain_sb_id = sb;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; lq_valid = '1; wb_ready = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if (draining !== 1'b0) begin n_fail++; $display("FAIL reset_draining got=%0b exp=0", draining); end
    n_checks++; if (wb_valid !== 1'b0 || wb_lqid !== 3'd0 || wb_sb_id !== 5'd0) begin n_fail++; $display("FAIL reset_wb got=%0b/%0d/%0d exp=0/0/0", wb_valid, wb_lqid, wb_sb_id); end
    n_checks++; if (lq_commit !== 1'b0 || dest_lqid !== 3'd0) begin n_fail++; $display("FAIL reset_commit got=%0b/%0d exp=0/0", lq_commit, dest_lqid); end
    n_checks++; if (drain_done !== 1'b0 || done_sb_id !== 5'd0) begin n_fail++; $display("FAIL reset_done got=%0b/%0d exp=0/0", drain_done, done_sb_id); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int t0;
    lq_valid = '1; wb_ready = 1'b1;
    t0 = cyc;
    request(3'd6, 4'd3, 5'd9);
    push_commit(3'd6, 5'd9, t0 + 1); push_commit(3'd7, 5'd9, t0 + 2);
    push_commit(3'd0, 5'd9, t0 + 3); push_done(5'd9, t0 + 4);
    @(negedge clk);
    n_checks++; if (draining !== 1'b0) begin n_fail++; $display("FAIL basic_draining_c0 got=%0b exp=0", draining); end
    step(); drain_req = 1'b0;
    @(negedge clk);
    n_checks++; if (draining !== 1'b1) begin n_fail++; $display("FAIL basic_draining_c1 got=%0b exp=1", draining); end
    wait_until(t0 + 5);
    @(negedge clk);
    n_checks++; if (draining !== 1'b0) begin n_fail++; $display("FAIL basic_draining_c5 got=%0b exp=0", draining); end
    n_checks++; if (cq.size() != 0 || dq.size() != 0) begin n_fail++; $display("FAIL basic_pending got=%0d/%0d exp=0/0", cq.size(), dq.size()); end
    step();
  endtask

  task automatic test_backpressure();
    int t0;
    lq_valid = '1; wb_ready = 1'b1;
    t0 = cyc;
    request(3'd6, 4'd3, 5'd3);
    push_commit(3'd6, 5'd3, t0 + 1); push_commit(3'd7, 5'd3, t0 + 4);
    push_commit(3'd0, 5'd3, t0 + 5); push_done(5'd3, t0 + 6);
    step(); drain_req = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      step(); wb_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (wb_valid !== 1'b1 || wb_lqid !== 3'd7 || wb_sb_id !== 5'd3) begin n_fail++; $display("FAIL bp_hold_c%0d got=%0b/%0d/%0d exp=1/7/3", c, wb_valid, wb_lqid, wb_sb_id); end
    end
    step(); wb_ready = 1'b1;
    wait_until(t0 + 7);
    @(negedge clk);
    n_checks++; if (cq.size() != 0 || dq.size() != 0) begin n_fail++; $display("FAIL bp_pending got=%0d/%0d exp=0/0", cq.size(), dq.size()); end
    step();
  endtask

  task automatic test_not_ready();
    int t0;
    lq_valid = 8'hFB; wb_ready = 1'b1;
    t0 = cyc;
    request(3'd1, 4'd2, 5'd4);
    push_commit(3'd1, 5'd4, t0 + 1); push_commit(3'd2, 5'd4, t0 + 5); push_done(5'd4, t0 + 6);
    step(); drain_req = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      step();
      @(negedge clk);
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL nr_valid_c%0d got=%0b exp=0", c, wb_valid); end
    end
    step(); lq_valid = '1;
    wait_until(t0 + 7);
    @(negedge clk);
    n_checks++; if (cq.size() != 0 || dq.size() != 0) begin n_fail++; $display("FAIL nr_pending got=%0d/%0d exp=0/0", cq.size(), dq.size()); end
    step();
  endtask

  task automatic test_count_zero();
    int t0;
    t0 = cyc;
    request(3'd3, 4'd0, 5'd17);
    push_done(5'd17, t0 + 1);
    step(); drain_req = 1'b0;
    @(negedge clk);
    n_checks++; if (draining !== 1'b1) begin n_fail++; $display("FAIL c0_draining_c1 got=%0b exp=1", draining); end
    step();
    @(negedge clk);
    n_checks++; if (draining !== 1'b0) begin n_fail++; $display("FAIL c0_draining_c2 got=%0b exp=0", draining); end
    n_checks++; if (cq.size() != 0 || dq.size() != 0) begin n_fail++; $display("FAIL c0_pending got=%0d/%0d exp=0/0", cq.size(), dq.size()); end
    step();
  endtask

  task automatic test_clamp_wrap();
    int t0;
    lq_valid = '1; wb_ready = 1'b1;
    t0 = cyc;
    request(3'd5, 4'd12, 5'd2);
    for (int i = 0; i < 8; i++) push_commit(3'((5 + i) % 8), 5'd2, t0 + 1 + i);
    push_done(5'd2, t0 + 9);
    step(); drain_req = 1'b0;
    wait_until(t0 + 10);
    @(negedge clk);
    n_checks++; if (draining !== 1'b0) begin n_fail++; $display("FAIL clamp_draining got=%0b exp=0", draining); end
    n_checks++; if (cq.size() != 0 || dq.size() != 0) begin n_fail++; $display("FAIL clamp_pending got=%0d/%0d exp=0/0", cq.size(), dq.size()); end
    step();
  endtask

  task automatic test_flush();
    int t0;
    lq_valid = '1; wb_ready = 1'b1;
    t0 = cyc;
    request(3'd0, 4'd4, 5'd6);
    push_commit(3'd0, 5'd6, t0 + 1);
    step(); drain_req = 1'b0;
    step(); flush = 1'b1;
    @(negedge clk);
    n_checks++; if (lq_commit !== 1'b0) begin n_fail++; $display("FAIL flush_commit got=%0b exp=0", lq_commit); end
    step(); flush = 1'b0;
    request(3'd4, 4'd1, 5'd8);
    push_commit(3'd4, 5'd8, t0 + 4); push_done(5'd8, t0 + 5);
    @(negedge clk);
    n_checks++; if (draining !== 1'b0) begin n_fail++; $display("FAIL flush_draining_c3 got=%0b exp=0", draining); end
    step(); drain_req = 1'b0;
    wait_until(t0 + 6);
    @(negedge clk);
    n_checks++; if (cq.size() != 0 || dq.size() != 0) begin n_fail++; $display("FAIL flush_pending got=%0d/%0d exp=0/0", cq.size(), dq.size()); end
    step();
  endtask

  task automatic test_back_to_back();
    int t0;
    lq_valid = '1; wb_ready = 1'b1;
    t0 = cyc;
    request(3'd2, 4'd2, 5'd10);
    push_commit(3'd2, 5'd10, t0 + 1); push_commit(3'd3, 5'd10, t0 + 2); push_done(5'd10, t0 + 3);
    push_commit(3'd7, 5'd11, t0 + 5); push_done(5'd11, t0 + 6);
    step();
    request(3'd7, 4'd1, 5'd11);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++; if (draining !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_c%0d got=%0b exp=1", c, draining); end
      step();
    end
    @(negedge clk);
    n_checks++; if (draining !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_c4 got=%0b exp=0", draining); end
    step(); drain_req = 1'b0;
    wait_until(t0 + 7);
    @(negedge clk);
    n_checks++; if (cq.size() != 0 || dq.size() != 0) begin n_fail++; $display("FAIL b2b_pending got=%0d/%0d exp=0/0", cq.size(), dq.size()); end
    step();
  endtask

  task automatic test_async_reset();
    int t0;
    lq_valid = '1; wb_ready = 1'b1;
    t0 = cyc;
    request(3'd0, 4'd4, 5'd12);
    push_commit(3'd0, 5'd12, t0 + 1);
    step(); drain_req = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (draining !== 1'b0 || wb_valid !== 1'b0 || wb_lqid !== 3'd0 || wb_sb_id !== 5'd0) begin n_fail++; $display("FAIL areset_wb got=%0b/%0b/%0d/%0d exp=0/0/0/0", draining, wb_valid, wb_lqid, wb_sb_id); end
    n_checks++; if (lq_commit !== 1'b0 || dest_lqid !== 3'd0 || drain_done !== 1'b0 || done_sb_id !== 5'd0) begin n_fail++; $display("FAIL areset_out got=%0b/%0d/%0b/%0d exp=0/0/0/0", lq_commit, dest_lqid, drain_done, done_sb_id); end
    step(); reset_n = 1'b1;
    wait_until(t0 + 7);
    @(negedge clk);
    n_checks++; if (draining !== 1'b0) begin n_fail++; $display("FAIL areset_idle got=%0b exp=0", draining); end
    n_checks++; if (cq.size() != 0 || dq.size() != 0) begin n_fail++; $display("FAIL areset_pending got=%0d/%0d exp=0/0", cq.size(), dq.size()); end
    step();
  endtask

  initial begin
    fork
      begin : monitor
        commit_t ce;
        done_t   de;
        forever begin
          @(negedge clk);
          if (reset_n) begin
            if (lq_commit) begin
              n_checks++;
              if (cq.size() == 0) begin
                n_fail++; $display("FAIL commit_unexpected lqid=%0d cycle=%0d exp=none", dest_lqid, cyc);
              end else begin
                ce = cq.pop_front();
                if (dest_lqid !== ce.lqid || wb_lqid !== ce.lqid || wb_sb_id !== ce.sb || cyc != ce.cyc) begin
                  n_fail++; $display("FAIL commit got lqid=%0d sb=%0d cycle=%0d exp lqid=%0d sb=%0d cycle=%0d", dest_lqid, wb_sb_id, cyc, ce.lqid, ce.sb, ce.cyc);
                end
              end
            end
            if (drain_done) begin
              n_checks++;
              if (dq.size() == 0) begin
                n_fail++; $display("FAIL done_unexpected sb=%0d cycle=%0d exp=none", done_sb_id, cyc);
              end else begin
                de = dq.pop_front();
                if (done_sb_id !== de.sb || cyc != de.cyc) begin
                  n_fail++; $display("FAIL done got sb=%0d cycle=%0d exp sb=%0d cycle=%0d", done_sb_id, cyc, de.sb, de.cyc);
                end
              end
            end
          end
        end
      end
      begin : stimulus
        test_reset();
        test_basic();
        test_backpressure();
        test_not_ready();
        test_count_zero();
        test_clamp_wrap();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    join
  end

endmodule
